// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter sharing one APB peripheral bus between NUM_MASTERS APB masters.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS-1:0]                m_psel_i,
  input  logic [NUM_MASTERS-1:0]                m_penable_i,
  input  logic [NUM_MASTERS-1:0]                m_pwrite_i,
  input  logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr_i,
  input  logic [NUM_MASTERS*32-1:0]             m_pwdata_i,
  output logic [31:0]                           m_prdata_o,
  output logic [NUM_MASTERS-1:0]                m_pready_o,
  output logic                                  m_pslverr_o,
  output logic                                  s_psel_o,
  output logic                                  s_penable_o,
  output logic                                  s_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]             s_paddr_o,
  output logic [31:0]                           s_pwdata_o,
  input  logic [31:0]                           s_prdata_i,
  input  logic                                  s_pready_i,
  input  logic                                  s_pslverr_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int unsigned N     = NUM_MASTERS;
  localparam int unsigned AW    = APB_ADDR_WIDTH;
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_d;
  logic [N-1:0]     m_pready_d;
  logic [DW-1:0]    m_prdata_d;
  logic             m_pslverr_d;
  logic             s_psel_d, s_penable_d, s_pwrite_d;
  logic [AW-1:0]    s_paddr_d;
  logic [DW-1:0]    s_pwdata_d;

  logic [N-1:0]     req;
  logic             found;
  logic [IDX_W-1:0] win, cand;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TO_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_W     = (TO_RAW_W < 8) ? 8 : ((TO_RAW_W > 16) ? 16 : TO_RAW_W);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            unused_ok;
  assign unused_ok = ^m_penable_i;
`else
  logic            unused_ok;
  assign unused_ok = ^{m_penable_i, TIMEOUT_CYCLES};
`endif

  // A master whose completion pulse is on the bus this cycle still shows its old PSEL; ignore it.
  assign req = m_psel_i & ~m_pready_o;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_o;
    m_pready_d  = '0;
    m_prdata_d  = m_prdata_o;
    m_pslverr_d = m_pslverr_o;
    s_psel_d    = s_psel_o;
    s_penable_d = s_penable_o;
    s_pwrite_d  = s_pwrite_o;
    s_paddr_d   = s_paddr_o;
    s_pwdata_d  = s_pwdata_o;
    found       = 1'b0;
    win         = ptr_q;
    cand        = '0;
`ifdef APB_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    // First requester after the last winner, wrapping around.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_SETUP;
          ptr_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          s_psel_d     = 1'b1;
          s_penable_d  = 1'b0;
          s_pwrite_d   = m_pwrite_i[win];
          s_paddr_d    = m_paddr_i[32'(win) * AW +: AW];
          s_pwdata_d   = m_pwdata_i[32'(win) * DW +: DW];
        end
      end
      S_SETUP: begin
        state_d     = S_ACCESS;
        s_penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
      end
      S_ACCESS: begin
        if (s_pready_i) begin
          state_d     = S_DONE;
          s_psel_d    = 1'b0;
          s_penable_d = 1'b0;
          m_prdata_d  = s_prdata_i;
          m_pslverr_d = s_pslverr_i;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_DONE;
          s_psel_d    = 1'b0;
          s_penable_d = 1'b0;
          m_prdata_d  = '0;
          m_pslverr_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_DONE: begin
        state_d    = S_IDLE;
        m_pready_d = grant_o;
        grant_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(N - 1);
      grant_o     <= '0;
      m_pready_o  <= '0;
      m_prdata_o  <= '0;
      m_pslverr_o <= 1'b0;
      s_psel_o    <= 1'b0;
      s_penable_o <= 1'b0;
      s_pwrite_o  <= 1'b0;
      s_paddr_o   <= '0;
      s_pwdata_o  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_o     <= grant_d;
      m_pready_o  <= m_pready_d;
      m_prdata_o  <= m_prdata_d;
      m_pslverr_o <= m_pslverr_d;
      s_psel_o    <= s_psel_d;
      s_penable_o <= s_penable_d;
      s_pwrite_o  <= s_pwrite_d;
      s_paddr_o   <= s_paddr_d;
      s_pwdata_o  <= s_pwdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: two APB master drivers, an APB memory slave and a
// completion monitor that pops expected responses on every m_pready_o pulse.
module tb_apb_bus_arbiter;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  m_psel_i, m_penable_i, m_pwrite_i;
  logic [23:0] m_paddr_i;
  logic [63:0] m_pwdata_i;
  logic [31:0] m_prdata_o;
  logic [1:0]  m_pready_o;
  logic        m_pslverr_o;
  logic        s_psel_o, s_penable_o, s_pwrite_o;
  logic [11:0] s_paddr_o;
  logic [31:0] s_pwdata_o;
  logic [31:0] s_prdata_i;
  logic        s_pready_i, s_pslverr_i;
  logic [1:0]  grant_o;

  apb_bus_arbiter #(
    .NUM_MASTERS(2), .APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_psel_i(m_psel_i), .m_penable_i(m_penable_i), .m_pwrite_i(m_pwrite_i),
    .m_paddr_i(m_paddr_i), .m_pwdata_i(m_pwdata_i),
    .m_prdata_o(m_prdata_o), .m_pready_o(m_pready_o), .m_pslverr_o(m_pslverr_o),
    .s_psel_o(s_psel_o), .s_penable_o(s_penable_o), .s_pwrite_o(s_pwrite_o),
    .s_paddr_o(s_paddr_o), .s_pwdata_o(s_pwdata_o),
    .s_prdata_i(s_prdata_i), .s_pready_i(s_pready_i), .s_pslverr_i(s_pslverr_i),
    .grant_o(grant_o)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          glog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [logic [11:0]];
  int          slv_wait, slv_rand, slv_stuck;
  logic [11:0] err_addr;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [11:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // APB memory slave with configurable wait states and an error address.
  initial begin
    int acc, cur_wait;
    acc = 0; cur_wait = 0;
    s_pready_i = 1'b0; s_prdata_i = '0; s_pslverr_i = 1'b0;
    forever begin
      @(negedge clk);
      if (s_psel_o && s_penable_o) begin
        if (acc == 0) cur_wait = slv_rand ? int'($urandom_range(0, 2)) : slv_wait;
        if (slv_stuck == 0 && acc >= cur_wait) begin
          s_pready_i  = 1'b1;
          s_prdata_i  = rd(s_paddr_o);
          s_pslverr_i = (s_paddr_o == err_addr);
          if (s_pwrite_o) mem[s_paddr_o] = s_pwdata_o;
          acc = 0;
        end else begin
          s_pready_i = 1'b0;
          acc++;
        end
      end else begin
        s_pready_i  = 1'b0;
        s_pslverr_i = 1'b0;
        acc = 0;
      end
    end
  end

  // Completion monitor and bus-level checks.
  initial begin
    logic [1:0]  pg;
    logic        pp;
    logic [11:0] pa;
    exp_t        e;
    bit          have;
    pg = '0; pp = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pg = '0; pp = 1'b0;
      end else begin
        chk("grant_onehot", 96'($onehot0(grant_o)), 96'd1);
        if (grant_o != 2'b00 && pg == 2'b00) glog.push_back(grant_o[1] ? 1 : 0);
        if (s_penable_o) chk("penable_without_psel", 96'(s_psel_o), 96'd1);
        if (s_psel_o && pp) chk("paddr_stable", 96'(s_paddr_o), 96'(pa));
        if (m_pready_o != 2'b00) chk("pready_onehot", 96'($onehot0(m_pready_o)), 96'd1);
        for (int m = 0; m < 2; m++) begin
          if (m_pready_o[m]) begin
            have = 1'b0;
            if (m == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (m == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
              checks++; errors++;
              $display("FAIL unexpected_pready m%0d: actual pulse required none", m);
            end else begin
              if (e.chk_data) chk("prdata", 96'(m_prdata_o), 96'(e.rdata));
              chk("pslverr", 96'(m_pslverr_o), 96'(e.err));
              if (e.lat > 0) chk("latency", 96'(cyc - e.issue), 96'(e.lat));
            end
          end
        end
        pg = grant_o; pp = s_psel_o; pa = s_paddr_o;
      end
    end
  end

  // One upstream APB transfer; expected completion pushed at issue time.
  task automatic apb_xfer(input int m, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic chk_data, input logic [31:0] erd, input logic eerr,
                          input int lat);
    exp_t e;
    int   n;
    e.chk_data = chk_data; e.rdata = erd; e.err = eerr; e.issue = cyc; e.lat = lat;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
    m_psel_i[m] = 1'b1; m_penable_i[m] = 1'b0; m_pwrite_i[m] = wr;
    m_paddr_i[m*12 +: 12] = a; m_pwdata_i[m*32 +: 32] = wd;
    @(posedge clk); #1;
    m_penable_i[m] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_pready_o[m] && n < 3000);
    if (!m_pready_o[m]) begin
      checks++; errors++;
      $display("FAIL xfer_timeout m%0d: no pready after %0d cycles, required pready", m, n);
    end
    @(posedge clk); #1;
    m_psel_i[m] = 1'b0; m_penable_i[m] = 1'b0;
  endtask

  task automatic rand_master(input int m);
    logic [31:0] sh [16];
    logic [11:0] a;
    logic [31:0] wd;
    int          idx;
    for (int k = 0; k < 16; k++) sh[k] = '0;
    for (int i = 0; i < 12; i++) begin
      idx = int'($urandom_range(0, 15));
      a   = ((m == 0) ? 12'h100 : 12'h200) + 12'(idx * 4);
      wd  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        sh[idx] = wd;
        apb_xfer(m, 1'b1, a, wd, 1'b0, 32'h0, 1'b0, 0);
      end else begin
        apb_xfer(m, 1'b0, a, 32'h0, 1'b1, sh[idx], 1'b0, 0);
      end
    end
  endtask

  initial begin
    int n, gb, acc_cycles;
    m_psel_i = '0; m_penable_i = '0; m_pwrite_i = '0; m_paddr_i = '0; m_pwdata_i = '0;
    slv_wait = 0; slv_rand = 0; slv_stuck = 0; err_addr = 12'hFFF;
    rst_i = 1'b0;
    #2 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_side", 96'({m_prdata_o, m_pready_o, m_pslverr_o, grant_o}), 96'd0);
    chk("reset_s_side", 96'({s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o}), 96'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Reset while a write sits in ACCESS against a stalled slave.
    slv_stuck = 1;
    m_psel_i[0] = 1'b1; m_pwrite_i[0] = 1'b1; m_paddr_i[11:0] = 12'h0FC; m_pwdata_i[31:0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    m_penable_i[0] = 1'b1;
    n = 0;
    while (!s_penable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_access", 96'(s_penable_o), 96'd1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    chk("midrst_m_side", 96'({m_prdata_o, m_pready_o, m_pslverr_o, grant_o}), 96'd0);
    chk("midrst_s_side", 96'({s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o}), 96'd0);
    m_psel_i = '0; m_penable_i = '0; slv_stuck = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Both masters request together, four transfers each: master0 first, then strict alternation.
    gb = glog.size();
    fork
      for (int i = 0; i < 4; i++) apb_xfer(0, 1'b1, 12'h040 + 12'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 0);
      for (int i = 0; i < 4; i++) apb_xfer(1, 1'b1, 12'h080 + 12'(i * 4), 32'h2000_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 0);
    join
    chk("rr_grant_count", 96'(glog.size() - gb), 96'd8);
    for (int k = 0; k < 8; k++)
      if (gb + k < glog.size()) chk("rr_grant_order", 96'(glog[gb + k]), 96'(k % 2));
    chk("rr_mem_m1", 96'(rd(12'h08C)), 96'h2000_0003);

    // Single zero-wait write: cycle-exact phase checks.
    fork
      apb_xfer(0, 1'b1, 12'h004, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 4);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("lat_setup", 96'({s_psel_o, s_penable_o, s_pwrite_o, s_paddr_o, s_pwdata_o, grant_o}),
            96'({1'b1, 1'b0, 1'b1, 12'h004, 32'hA5A5_0001, 2'b01}));
        @(negedge clk);
        chk("lat_access", 96'({s_psel_o, s_penable_o}), 96'b11);
        @(negedge clk);
        chk("lat_done", 96'({s_psel_o, s_penable_o, m_pready_o}), 96'd0);
        @(negedge clk);
        chk("lat_pready", 96'(m_pready_o), 96'b01);
        @(negedge clk);
        chk("lat_pready_once", 96'(m_pready_o), 96'b00);
      end
    join
    chk("lat_mem", 96'(rd(12'h004)), 96'hA5A5_0001);

    // M1 read with 3 wait states and slave error; M0 arrives mid-transfer and is served next.
    mem[12'h010] = 32'h1234_5678; err_addr = 12'h010; slv_wait = 3;
    gb = glog.size();
    fork
      apb_xfer(1, 1'b0, 12'h010, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 7);
      begin
        repeat (2) @(posedge clk);
        #1 apb_xfer(0, 1'b1, 12'h020, 32'hCAFE_0004, 1'b0, 32'h0, 1'b0, 0);
      end
    join
    chk("stall_grant_count", 96'(glog.size() - gb), 96'd2);
    if (gb + 1 < glog.size()) begin
      chk("stall_first", 96'(glog[gb]), 96'd1);
      chk("stall_second", 96'(glog[gb + 1]), 96'd0);
    end
    chk("stall_mem", 96'(rd(12'h020)), 96'hCAFE_0004);
    slv_wait = 0; err_addr = 12'hFFF;

    // Slave never ready.
    slv_stuck = 1;
    fork
`ifdef APB_ARB_TIMEOUT_EN
      apb_xfer(0, 1'b0, 12'h004, 32'h0, 1'b1, 32'h0, 1'b1, 0);
`else
      apb_xfer(0, 1'b0, 12'h004, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0, 0);
`endif
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!s_penable_o && n < 20);
        acc_cycles = 0;
`ifdef APB_ARB_TIMEOUT_EN
        while (s_psel_o && s_penable_o && acc_cycles < 50) begin
          acc_cycles++;
          @(negedge clk);
        end
        chk("timeout_access_cycles", 96'(acc_cycles), 96'd4);
`else
        repeat (1000) begin
          if (s_psel_o && s_penable_o) acc_cycles++;
          @(negedge clk);
        end
        chk("no_timeout_hold", 96'(acc_cycles), 96'd1000);
`endif
        slv_stuck = 0;
      end
    join

    // Concurrent random traffic, each master in its own address window.
    slv_rand = 1;
    fork
      rand_master(0);
      rand_master(1);
    join
    slv_rand = 0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 96'(q0.size() + q1.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
